ps2_device_tx: RTL

Device-side PS/2 transmitter: models a keyboard that serialises scan-code bytes onto ps2_clk/ps2_data for the host-side PS/2 receiver in simulation and FPGA loopback. Bytes are pushed through a valid/ready port into an internal FIFO. Each byte is sent as an 11-bit frame (start 0, 8 data LSB first, odd parity, stop 1) at a divided PS/2 clock. A host-inhibit input aborts and later retransmits a frame.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_tx_fifo.sv | 47 ++++
 rtl/ps2_device_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and frame helpers for the device-side PS/2 transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BIT_HIGH = 2'd1,
        BIT_LOW  = 2'd2,
        GAP      = 2'd3
    } ps2_state_t;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Bit idx of the 11-bit frame: start, d[0]..d[7], parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic       r;
        logic [3:0] j;
        j = idx - 4'd1;
        if (idx == 4'd0)
            r = START_BIT;
        else if (idx <= 4'd8)
            r = b[j[2:0]];
        else if (idx == 4'd9)
            r = odd_parity(b);
        else
            r = STOP_BIT;
        return r;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO feeding the PS/2 transmitter; pointers carry one extra wrap bit.
module ps2_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: FIFO-fed, 11-bit frames, host inhibit aborts and retries.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          inhibit,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned CNT_MAX   = (HALF_CYCLES > GAP_CYCLES) ? HALF_CYCLES : GAP_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    ps2_state_t  state;
    logic [3:0]  bit_idx;
    logic [3:0]  next_bit;
    logic [CW-1:0] cnt;
    logic [7:0]  tx_byte;
    logic        retry;
    logic        clk_r;
    logic        data_r;

    logic [7:0]  fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        start;
    logic        abort;
    logic        half_done;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign start     = (state == IDLE) && (!fifo_empty || retry) && !inhibit;
    // A pending retry replays the held byte, so the FIFO head stays put.
    assign fifo_pop  = start && !retry;
    assign abort     = ((state == BIT_HIGH) || (state == BIT_LOW)) && inhibit && (bit_idx != LAST_BIT);
    assign half_done = (cnt == HALF_LAST);
    assign next_bit  = bit_idx + 4'd1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            bit_idx <= '0;
            cnt     <= '0;
            tx_byte <= '0;
            retry   <= 1'b0;
            clk_r   <= 1'b1;
            data_r  <= 1'b1;
        end else if (abort) begin
            clk_r  <= 1'b1;
            data_r <= 1'b1;
            retry  <= 1'b1;
            cnt    <= '0;
            state  <= GAP;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (retry)
                            retry <= 1'b0;
                        else
                            tx_byte <= fifo_rd;
                        bit_idx <= '0;
                        cnt     <= '0;
                        clk_r   <= 1'b1;
                        data_r  <= START_BIT;
                        state   <= BIT_HIGH;
                    end
                end
                BIT_HIGH: begin
                    if (half_done) begin
                        cnt   <= '0;
                        clk_r <= 1'b0;
                        state <= BIT_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (half_done) begin
                        cnt   <= '0;
                        clk_r <= 1'b1;
                        if (bit_idx != LAST_BIT) begin
                            bit_idx <= next_bit;
                            data_r  <= frame_bit(tx_byte, next_bit);
                            state   <= BIT_HIGH;
                        end else begin
                            data_r <= 1'b1;
                            state  <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    // Counter saturates while the host keeps inhibiting.
                    if (cnt == GAP_LAST) begin
                        if (!inhibit) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ps2_clk  = clk_r;
    assign ps2_data = data_r;
    assign in_ready = ~fifo_full;
    assign busy     = (state != IDLE) | (level != '0) | retry;

endmodule
